rng_e_gen: RTL and testbench

Public-exponent candidate source for RSA key generation. It is the requesting end of the start / should_redo / valid handshake toward the GCD(phi, e) == 1 checker. On a generate request it draws an odd random e with 3 <= e < phi, presents it to the checker with a start pulse, and redraws on every should_redo. It stops when the checker reports valid or when the retry budget is exhausted.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/rng_lfsr.sv | 35 +++
 rtl/rng_e_gen.sv | 132 +++++++++++++
 tb/tb_rng_e_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and helpers for RSA key-generation blocks
package rsa_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAW    = 3'd1;
    localparam logic [2:0] ST_QUALIFY = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_FAIL    = 3'd6;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] E_F4      = 32'd65537;
    localparam logic [31:0] E_MIN     = 32'd3;

    // All ones from bit 0 up to and including the MSB of v.
    function automatic logic [31:0] msb_mask(input logic [31:0] v);
        logic [31:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rng_lfsr.sv
// rtl/rng_lfsr.sv - free-running 32-bit Galois LFSR, steps every cycle after reset
module rng_lfsr
    import rsa_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] state
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_NZ;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/rng_e_gen.sv
// rtl/rng_e_gen.sv - RSA public-exponent candidate source; RNG_E_F4_FIRST_EN offers 65537 first
module rng_e_gen
    import rsa_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 64,
    parameter logic [31:0] SEED      = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen,
    input  logic [31:0] phi,
    input  logic        should_redo,
    input  logic        valid,
    output logic [31:0] rng_e,
    output logic        start,
    output logic        busy,
    output logic        key_ok,
    output logic        fail,
    output logic [7:0]  attempts
);

    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    logic [2:0]  state_q,    state_d;
    logic [31:0] phi_q,      phi_d;
    logic [31:0] cand_q,     cand_d;
    logic [31:0] rng_e_q,    rng_e_d;
    logic        start_q,    start_d;
    logic [7:0]  attempts_q, attempts_d;

    logic [31:0] lfsr;
    logic [31:0] mask;
    logic        idle_like;

    rng_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign mask      = msb_mask(phi_q);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);

    // rng_e, start and attempts load on entry to ISSUE so the start pulse
    // coincides with the ISSUE cycle and rng_e is valid alongside it.
    always_comb begin
        state_d    = state_q;
        phi_d      = phi_q;
        cand_d     = cand_q;
        rng_e_d    = rng_e_q;
        start_d    = 1'b0;
        attempts_d = attempts_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (gen) begin
                    phi_d      = phi;
                    attempts_d = 8'd0;
                    if (phi < 32'd4) begin
                        state_d = ST_FAIL;
                    end else begin
`ifdef RNG_E_F4_FIRST_EN
                        if (E_F4 < phi) begin
                            state_d    = ST_ISSUE;
                            rng_e_d    = E_F4;
                            start_d    = 1'b1;
                            attempts_d = 8'd1;
                        end else begin
                            state_d = ST_DRAW;
                        end
`else
                        state_d = ST_DRAW;
`endif
                    end
                end
            end
            ST_DRAW: begin
                cand_d  = (lfsr & mask) | 32'd1;
                state_d = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if ((cand_q >= E_MIN) && (cand_q < phi_q)) begin
                    state_d    = ST_ISSUE;
                    rng_e_d    = cand_q;
                    start_d    = 1'b1;
                    attempts_d = attempts_q + 8'd1;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (valid) begin
                    state_d = ST_DONE;
                end else if (should_redo) begin
                    state_d = (attempts_q == MAX_T) ? ST_FAIL : ST_DRAW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phi_q      <= 32'd0;
            cand_q     <= 32'd0;
            rng_e_q    <= 32'd0;
            start_q    <= 1'b0;
            attempts_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            phi_q      <= phi_d;
            cand_q     <= cand_d;
            rng_e_q    <= rng_e_d;
            start_q    <= start_d;
            attempts_q <= attempts_d;
        end
    end

    assign rng_e    = rng_e_q;
    assign start    = start_q;
    assign attempts = attempts_q;
    assign busy     = !idle_like;
    assign key_ok   = (state_q == ST_DONE);
    assign fail     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_rng_e_gen.sv
// tb/tb_rng_e_gen.sv - scoreboard bench for rng_e_gen with a cycle-level reference model
module tb_rng_e_gen;

    localparam int          MAXT   = 4;
    localparam logic [31:0] SEED_V = 32'h1234_5678;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen = 1'b0;
    logic [31:0] phi = 32'd0;
    logic        should_redo = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] rng_e;
    logic        start;
    logic        busy;
    logic        key_ok;
    logic        fail;
    logic [7:0]  attempts;

    rng_e_gen #(.MAX_TRIES(MAXT), .SEED(SEED_V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gen         (gen),
        .phi         (phi),
        .should_redo (should_redo),
        .valid       (valid),
        .rng_e       (rng_e),
        .start       (start),
        .busy        (busy),
        .key_ok      (key_ok),
        .fail        (fail),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e;
        int          at;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_x;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_start = 0;
    logic [31:0] m_lfsr;
    logic [31:0] last_e;
    logic [31:0] cur_phi = 32'd0;

    function automatic logic [31:0] nxt(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ TAPS;
        return x >> 1;
    endfunction

    function automatic logic [31:0] bound_mask(input logic [31:0] p);
        int top = 0;
        for (int i = 0; i < 32; i++) if (p[i]) top = i;
        return 32'((64'd1 << (top + 1)) - 64'd1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED_V;
        else        m_lfsr <= nxt(m_lfsr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Draw j after the triggering edge uses the LFSR stepped 1+2j times from its value
    // in the triggering cycle; each rejection costs two cycles.
    task automatic predict(input logic [31:0] cur, input logic [31:0] p, input int base);
        logic [31:0] v = cur;
        logic [31:0] c;
        for (int k = 0; k < 400; k++) begin
            v = nxt(v);
            c = (v & bound_mask(p)) | 32'd1;
            if (c >= 32'd3 && c < p) begin
                q.push_back('{c, base + 3 + 2 * k});
                return;
            end
            v = nxt(v);
        end
    endtask

    task automatic push_first(input logic [31:0] cur, input logic [31:0] p, input int base);
`ifdef RNG_E_F4_FIRST_EN
        if (32'd65537 < p) begin
            q.push_back('{32'd65537, base + 1});
            return;
        end
`endif
        predict(cur, p, base);
    endtask

    initial begin
        last_e = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_e = '0;
            end else if (start) begin
                n_start++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start actual=%0h required=none at cycle %0d", rng_e, cyc);
                end else begin
                    mon_x = q.pop_front();
                    chk("start_e", rng_e, mon_x.e);
                    chk("start_cycle", cyc, mon_x.at);
                end
                chk("e_odd", {31'd0, rng_e[0]}, 32'd1);
                chk("e_range", {31'd0, (rng_e >= 32'd3) && (rng_e < cur_phi)}, 32'd1);
                last_e = rng_e;
            end else begin
                chk("e_stable", rng_e, last_e);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic issue_gen(input logic [31:0] p);
        gen = 1'b1;
        phi = p;
        cur_phi = p;
        if (p >= 32'd4) push_first(m_lfsr, p, cyc);
        @(negedge clk);
        gen = 1'b0;
        phi = $urandom;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL start_timeout actual=none required=start at cycle %0d", cyc);
            q.delete();
        end
    endtask

    task automatic respond(input bit redo, input bit vld, input bit stray, input int a);
        int d = $urandom_range(1, 3);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            gen = stray && (i == 0);
            phi = $urandom;
        end
        should_redo = redo;
        valid = vld;
        if (redo && !vld && a < MAXT) predict(m_lfsr, cur_phi, cyc);
        @(negedge clk);
        gen = 1'b0;
        should_redo = 1'b0;
        valid = 1'b0;
    endtask

    task automatic run_req(input logic [31:0] p, input int n_redo, input bit both, input bit stray);
        int  s0 = n_start;
        int  n_exp;
        bit  ok;
        issue_gen(p);
        chk("busy_after_gen", {31'd0, busy}, 32'd1);
        chk("fail_cleared", {31'd0, fail}, 32'd0);
        chk("key_ok_cleared", {31'd0, key_ok}, 32'd0);
        for (int a = 1; a <= MAXT; a++) begin
            wait_start(ok);
            if (!ok) break;
            if (a <= n_redo) respond(1'b1, 1'b0, stray, a);
            else begin
                respond(both, 1'b1, stray, a);
                break;
            end
        end
        n_exp = (n_redo >= MAXT) ? MAXT : n_redo + 1;
        chk("key_ok_end", {31'd0, key_ok}, {31'd0, n_redo < MAXT});
        chk("fail_end", {31'd0, fail}, {31'd0, n_redo >= MAXT});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("attempts_end", {24'd0, attempts}, 32'(n_exp));
        repeat (5) @(negedge clk);
        #1;
        chk("start_count", 32'(n_start - s0), 32'(n_exp));
        chk("attempts_hold", {24'd0, attempts}, 32'(n_exp));
    endtask

    initial begin
        int s0;
        bit ok;
        logic [31:0] p;

        repeat (3) @(negedge clk);
        chk("rst_rng_e", rng_e, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_key_ok", {31'd0, key_ok}, 32'd0);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_attempts", {24'd0, attempts}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_req(32'd3120, 2, 1'b0, 1'b0);

        s0 = n_start;
        issue_gen(32'd2);
        chk("small_phi_fail", {31'd0, fail}, 32'd1);
        chk("small_phi_busy", {31'd0, busy}, 32'd0);
        chk("small_phi_attempts", {24'd0, attempts}, 32'd0);
        repeat (4) @(negedge clk);
        chk("small_phi_nostart", 32'(n_start - s0), 32'd0);

        run_req(32'd3120, MAXT, 1'b0, 1'b0);
        run_req(32'd5000, 0, 1'b0, 1'b0);
        run_req(32'd3120, 1, 1'b1, 1'b0);

        issue_gen(32'd3120);
        wait_start(ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rng_e", rng_e, 32'd0);
        chk("midrst_start", {31'd0, start}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_key_ok", {31'd0, key_ok}, 32'd0);
        chk("midrst_fail", {31'd0, fail}, 32'd0);
        chk("midrst_attempts", {24'd0, attempts}, 32'd0);
        chk("midrst_queue", 32'(q.size()), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(32'd3120, 0, 1'b0, 1'b0);

        run_req(32'd100000, 1, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            case (t % 3)
                0:       p = 32'($urandom_range(4, 300));
                1:       p = $urandom | 32'h10;
                default: p = 32'd100000;
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req(p, $urandom_range(0, MAXT), 1'($urandom_range(0, 1)), 1'b1);
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
